// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings and widths for the pipeline hazard controller and its scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // E-stage operand mux selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Default register address width (32 architectural registers)
    localparam int DEF_REG_AW = 5;

    // Outstanding long-op counter width; holds MAX_PENDING up to 15
    localparam int PCNT_W = 4;

    // Stall watchdog counter width
    localparam int WD_W = 8;

endpackage

// File: rtl/pipeline_hazard_controller_reg_scoreboard.sv
// Register scoreboard: busy bits for long-latency destinations plus outstanding-op count.
// Latency: busy/count update on the clock edge; read ports are combinational with same-cycle retire bypass.
// Backpressure: none internally; the caller stalls issue when the count is at its limit.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              done,
    input  logic [REG_AW-1:0] done_rd,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    input  logic [REG_AW-1:0] rd_addr_c,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_c,
    output logic [PCNT_W-1:0] pending_cnt
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam logic [PCNT_W-1:0] MAX_CNT = PCNT_W'(MAX_PENDING);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // A result retiring this cycle is written first in the regfile, so it no longer blocks a reader.
    function automatic logic busy_eff(input logic [REG_AW-1:0] r);
        return (r != '0) && busy[r] && !(done && (done_rd == r));
    endfunction

    assign busy_a = busy_eff(rd_addr_a);
    assign busy_b = busy_eff(rd_addr_b);
    assign busy_c = busy_eff(rd_addr_c);

    // Next busy vector: clear on retire, then set on issue so a new issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (done) begin
            busy_next[done_rd] = 1'b0;
        end
        if (issue) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Outstanding-op count: saturating at 0 (stray retire) and at the configured limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_cnt <= '0;
        end else if (issue && !done) begin
            if (pending_cnt != MAX_CNT) begin
                pending_cnt <= pending_cnt + 1'b1;
            end
        end else if (done && !issue) begin
            if (pending_cnt != '0) begin
                pending_cnt <= pending_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard control for the 5-stage pipeline: M/W forwarding, load-use/scoreboard/structural stalls, branch flush, stall watchdog.
// Latency: stall/flush/forward are combinational from the current stage fields; scoreboard and watchdog update each clock edge.
// Backpressure: StallF/StallD hold fetch and decode while a hazard is open; a taken branch always overrides the stall.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_AW        = DEF_REG_AW,
    parameter int MAX_PENDING   = 4,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rd_D,
    input  logic              RegWriteD,
    input  logic              LongOpD,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic              RegWriteE,
    input  logic              MemReadE,
    input  logic              LongIssueE,
    input  logic              BranchTakenE,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LongDoneValid,
    input  logic [REG_AW-1:0] LongDoneRd,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [3:0]        PendingCnt,
    output logic              Deadlock
);

    localparam logic [PCNT_W-1:0] MAX_CNT = PCNT_W'(MAX_PENDING);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(STALL_TIMEOUT);

    logic              issue;
    logic              busy_rs1;
    logic              busy_rs2;
    logic              busy_rd;
    logic              lu;
    logic              sb;
    logic              st;
    logic              hz;
    logic [PCNT_W-1:0] pending_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_inc;

    // Only register-writing long ops to a real register occupy a scoreboard slot.
    assign issue = LongIssueE && RegWriteE && (RD_E != '0);

    reg_scoreboard #(
        .REG_AW      (REG_AW),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue       (issue),
        .issue_rd    (RD_E),
        .done        (LongDoneValid),
        .done_rd     (LongDoneRd),
        .rd_addr_a   (Rs1_D),
        .rd_addr_b   (Rs2_D),
        .rd_addr_c   (Rd_D),
        .busy_a      (busy_rs1),
        .busy_b      (busy_rs2),
        .busy_c      (busy_rd),
        .pending_cnt (pending_cnt)
    );

    assign PendingCnt = pending_cnt;

    // Hazard sources: load result not ready, scoreboarded operand/destination, long unit full.
    always_comb begin
        lu = MemReadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
        sb = busy_rs1 || busy_rs2 || (RegWriteD && busy_rd);
        st = LongOpD && (pending_cnt == MAX_CNT);
        hz = lu || sb || st;
    end

    // Operand forwarding and pipeline-register controls; everything idles while reset is held.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!reset) begin
            if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E)) begin
                ForwardAE = FWD_M;
            end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) begin
                ForwardAE = FWD_W;
            end
            if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E)) begin
                ForwardBE = FWD_M;
            end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) begin
                ForwardBE = FWD_W;
            end
            // The redirect must never be held back by a stall on the wrong path.
            FlushD = BranchTakenE;
            FlushE = BranchTakenE || hz;
            StallF = hz && !BranchTakenE;
            StallD = hz && !BranchTakenE;
        end
    end

    assign wd_inc = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;

    // Watchdog: count consecutive decode stalls; latch Deadlock once the run reaches the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt   <= '0;
            Deadlock <= 1'b0;
        end else if (StallD) begin
            wd_cnt <= wd_inc;
            if (wd_inc >= WD_LIMIT) begin
                Deadlock <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule
